vector_data_memory_strided: RTL and testbench
=============================================

Name: vector_data_memory_strided

Overview:
Parametrised successor of the vector data memory. Byte-organised RAM serving whole-vector loads and stores for the vector CPU datapath. Adds element stride, per-lane mask, and multi-beat sequencing (LPB lanes per cycle) behind a ready/valid handshake. Sits between the vector register file and the memory stage control.

Parameters:
LANES, 16, vector lanes per request
ELEM_W, 16, element width in bits, multiple of 8
ADDR_W, 16, byte address width
DEPTH, 512, memory size in bytes, power of two
LPB, 4, lanes processed per beat, divides LANES
STRIDE_W, 8, unsigned stride width (in elements)

Ports:
CLK  in  1  clock, all logic rising-edge
RST  in  1  synchronous active-high reset
REQ  in  1  request strobe
WE  in  1  1=store, 0=load (sampled with REQ)
A  in  ADDR_W  base byte address
STRIDE  in  STRIDE_W  element stride, 1 = contiguous
MASK  in  LANES  lane enable, bit i = lane i
WD  in  LANES x ELEM_W  store data
READY  out  1  request acceptable this cycle
VALID  out  1  one-cycle completion pulse
RD  out  LANES x ELEM_W  load data

Behaviour:
- One clock CLK; reset RST synchronous, active-high.
- EB = ELEM_W/8; NB = LANES/LPB beats.
- Lane i address = (A + i*STRIDE*EB) mod DEPTH; element bytes little-endian, byte j at (addr+j) mod DEPTH (wrap at top).
- Reset: state IDLE, READY=1, VALID=0, RD=0, beat counter 0. RAM contents not cleared. RST mid-BUSY aborts; beats already written stay committed.
- States: IDLE -> BUSY -> DONE -> IDLE.
- IDLE: READY=1. Edge with REQ=1 captures A, WE, STRIDE, MASK, WD; -> BUSY, beat=0.
- BUSY: READY=0. Each edge processes lanes beat*LPB .. beat*LPB+LPB-1; beat++; after beat NB-1 -> DONE.
- Store: enabled lanes write EB bytes each. Masked lanes write nothing.
- Load: enabled lanes load RD lane register; masked lanes load 0.
- DONE: VALID=1 for exactly one cycle, READY=0; next edge -> IDLE.
- Latency: request accepted edge k; VALID high during cycle after edge k+NB; READY high again after edge k+NB+1. Defaults: NB=4, 6 cycles per request.
- REQ while READY=0 ignored; not queued.
- RD valid when VALID=1. Held until the next load is accepted. Stores never alter RD.
- Byte collisions within one request (e.g. STRIDE=0): later beat wins. Within a beat, higher lane index wins.
- Load after store sees stored data. No same-cycle RAM read/write hazard, since requests never overlap.
- Address arithmetic at ADDR_W+STRIDE_W+log2(LANES) bits, then reduced mod DEPTH.

Test Plan:
1. Reset, then store A=0x0000 STRIDE=1 MASK=0xFFFF WD[i]=i+1, then load the same address -> RD[i]=i+1. VALID pulses once per request, 6 cycles apart after accept.
2. Store A=0x0010 STRIDE=2 WD[i]=0x0100+i, then load STRIDE=1 at 0x0010 -> even lanes 0x0100..0x0107, odd lanes hold prior contents.
3. Load with MASK=0x00FF -> RD[8..15]=0. Store with MASK=0x0001 WD[0]=0xBEEF -> only bytes A, A+1 change.
4. Store A=0x01FE (DEPTH=512) STRIDE=1 -> lane0 at bytes 0x1FE/0x1FF, lane1 at 0x000/0x001. A readback load matches.
5. Store STRIDE=0 WD[i]=i -> readback element = 15. REQ held high during BUSY -> exactly one request serviced.
6. Assert RST after beat 1 of a store -> READY=1, VALID=0 next cycle. Lanes 0-7 written, lanes 8-15 unchanged.

Source files
------------

// File: rtl/vector_data_memory_strided.sv
// Byte-organised vector data memory with element stride, per-lane mask and
// multi-beat (LPB lanes per cycle) sequencing behind a ready/valid handshake.
module vector_data_memory_strided #(
  parameter int LANES    = 16,
  parameter int ELEM_W   = 16,
  parameter int ADDR_W   = 16,
  parameter int DEPTH    = 512,
  parameter int LPB      = 4,
  parameter int STRIDE_W = 8
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      REQ,
  input  logic                      WE,
  input  logic [ADDR_W-1:0]         A,
  input  logic [STRIDE_W-1:0]       STRIDE,
  input  logic [LANES-1:0]          MASK,
  input  logic [LANES*ELEM_W-1:0]   WD,
  output logic                      READY,
  output logic                      VALID,
  output logic [LANES*ELEM_W-1:0]   RD
);

  localparam int EB  = ELEM_W / 8;
  localparam int NB  = LANES / LPB;
  localparam int DW  = $clog2(DEPTH);
  localparam int BW  = (NB > 1) ? $clog2(NB) : 1;
  localparam int LIW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int AW  = ADDR_W + STRIDE_W + $clog2(LANES);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t                    state_q;
  state_t                    state_d;
  logic [BW-1:0]             beat_q;
  logic                      beat_last;
  logic                      we_q;
  logic [ADDR_W-1:0]         a_q;
  logic [STRIDE_W-1:0]       stride_q;
  logic [LANES-1:0]          mask_q;
  logic [LANES*ELEM_W-1:0]   wd_q;
  logic [LANES*ELEM_W-1:0]   rd_q;
  logic [LIW-1:0]            lane_idx  [LPB];
  logic [DW-1:0]             lane_addr [LPB];
  logic [7:0]                mem       [DEPTH];

  assign beat_last = (beat_q == BW'(NB - 1));
  assign RD        = rd_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    READY   = 1'b0;
    VALID   = 1'b0;
    case (state_q)
      IDLE: begin
        READY = 1'b1;
        if (REQ) begin
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (beat_last) begin
          state_d = DONE;
        end
      end
      DONE: begin
        VALID   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // The whole request is latched at accept so the caller may change inputs
  // freely while the beats run.
  always_ff @(posedge CLK) begin
    if (state_q == IDLE && REQ) begin
      we_q     <= WE;
      a_q      <= A;
      stride_q <= STRIDE;
      mask_q   <= MASK;
      wd_q     <= WD;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      beat_q <= '0;
    end else if (state_q != BUSY || beat_last) begin
      beat_q <= '0;
    end else begin
      beat_q <= beat_q + 1'b1;
    end
  end

  // Address arithmetic is done wide and then truncated, which equals mod DEPTH.
  always_comb begin
    for (int l = 0; l < LPB; l++) begin
      lane_idx[l]  = LIW'(int'(beat_q) * LPB + l);
      lane_addr[l] = DW'(AW'(a_q) + AW'(lane_idx[l]) * AW'(stride_q) * AW'(EB));
    end
  end

  // Later lanes in the loop issue later non-blocking writes, so the higher
  // lane index wins on a byte collision within a beat.
  always_ff @(posedge CLK) begin
    if (!RST && state_q == BUSY && we_q) begin
      for (int l = 0; l < LPB; l++) begin
        if (mask_q[lane_idx[l]]) begin
          for (int j = 0; j < EB; j++) begin
            mem[DW'(lane_addr[l] + DW'(j))] <= wd_q[int'(lane_idx[l]) * ELEM_W + 8 * j +: 8];
          end
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      rd_q <= '0;
    end else if (state_q == BUSY && !we_q) begin
      for (int l = 0; l < LPB; l++) begin
        for (int j = 0; j < EB; j++) begin
          rd_q[int'(lane_idx[l]) * ELEM_W + 8 * j +: 8] <=
            mask_q[lane_idx[l]] ? mem[DW'(lane_addr[l] + DW'(j))] : 8'h00;
        end
      end
    end
  end

endmodule

// File: tb/tb_vector_data_memory_strided.sv
// Directed self-checking bench for vector_data_memory_strided at default
// parameters (16 lanes x 16 bits, 512-byte RAM, 4 lanes per beat).
module tb_vector_data_memory_strided;

  logic         clk;
  logic         RST;
  logic         REQ;
  logic         WE;
  logic [15:0]  A;
  logic [7:0]   STRIDE;
  logic [15:0]  MASK;
  logic [255:0] WD;
  logic         READY;
  logic         VALID;
  logic [255:0] RD;

  int checks   = 0;
  int failures = 0;

  vector_data_memory_strided dut (
    .CLK    (clk),
    .RST    (RST),
    .REQ    (REQ),
    .WE     (WE),
    .A      (A),
    .STRIDE (STRIDE),
    .MASK   (MASK),
    .WD     (WD),
    .READY  (READY),
    .VALID  (VALID),
    .RD     (RD)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one request and waits (bounded) for its VALID pulse; lat is the
  // number of edges after accept until VALID is seen, -1 on timeout.
  task automatic run_request(input logic we, input logic [15:0] a, input logic [7:0] stride,
                             input logic [15:0] mask, input logic [255:0] wd,
                             output int lat, output logic ready_after, output logic valid_after);
    @(negedge clk);
    REQ = 1'b1; WE = we; A = a; STRIDE = stride; MASK = mask; WD = wd;
    @(posedge clk); #1;
    REQ = 1'b0;
    lat = -1;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (VALID === 1'b1) begin
        lat = c;
        break;
      end
    end
    @(posedge clk); #1;
    ready_after = READY;
    valid_after = VALID;
  endtask

  task automatic test_reset();
    RST = 1'b1; REQ = 1'b0; WE = 1'b0; A = '0; STRIDE = '0; MASK = '0; WD = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (READY !== 1'b1) begin failures++; $display("[TB] FAIL reset_ready: got %b expected 1", READY); end
    checks++;
    if (VALID !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid: got %b expected 0", VALID); end
    checks++;
    if (RD !== 256'h0) begin failures++; $display("[TB] FAIL reset_rd: got %h expected 0", RD); end
    @(negedge clk);
    RST = 1'b0;
  endtask

  task automatic test_contiguous();
    logic [255:0] wd, exp;
    int lat;
    logic ra, va;
    for (int i = 0; i < 16; i++) wd[i*16 +: 16] = 16'(i + 1);
    run_request(1'b1, 16'h0000, 8'd1, 16'hFFFF, wd, lat, ra, va);
    checks++;
    if (lat !== 4) begin failures++; $display("[TB] FAIL store_latency: got %0d expected 4", lat); end
    checks++;
    if (va !== 1'b0) begin failures++; $display("[TB] FAIL valid_one_cycle: got %b expected 0", va); end
    checks++;
    if (ra !== 1'b1) begin failures++; $display("[TB] FAIL ready_after_done: got %b expected 1", ra); end
    run_request(1'b0, 16'h0000, 8'd1, 16'hFFFF, 256'h0, lat, ra, va);
    checks++;
    if (lat !== 4) begin failures++; $display("[TB] FAIL load_latency: got %0d expected 4", lat); end
    exp = wd;
    checks++;
    if (RD !== exp) begin failures++; $display("[TB] FAIL contiguous_load: got %h expected %h", RD, exp); end
  endtask

  task automatic test_stride();
    logic [255:0] wd, exp;
    int lat;
    logic ra, va;
    for (int i = 0; i < 16; i++) wd[i*16 +: 16] = 16'hA000 + 16'(i);
    run_request(1'b1, 16'h0020, 8'd1, 16'hFFFF, wd, lat, ra, va);
    for (int i = 0; i < 16; i++) wd[i*16 +: 16] = 16'h0100 + 16'(i);
    run_request(1'b1, 16'h0010, 8'd2, 16'hFFFF, wd, lat, ra, va);
    checks++;
    if (lat !== 4) begin failures++; $display("[TB] FAIL stride_store_latency: got %0d expected 4", lat); end
    run_request(1'b0, 16'h0010, 8'd1, 16'hFFFF, 256'h0, lat, ra, va);
    for (int i = 0; i < 8; i++) begin
      exp[(2*i)*16 +: 16]   = 16'h0100 + 16'(i);
      exp[(2*i+1)*16 +: 16] = (i < 4) ? 16'h000A + 16'(2*i) : 16'hA001 + 16'(2*(i-4));
    end
    checks++;
    if (RD !== exp) begin failures++; $display("[TB] FAIL stride2_readback: got %h expected %h", RD, exp); end
  endtask

  task automatic test_mask();
    logic [255:0] wd, exp;
    int lat;
    logic ra, va;
    run_request(1'b0, 16'h0010, 8'd1, 16'h00FF, 256'h0, lat, ra, va);
    exp = '0;
    for (int i = 0; i < 4; i++) begin
      exp[(2*i)*16 +: 16]   = 16'h0100 + 16'(i);
      exp[(2*i+1)*16 +: 16] = 16'h000A + 16'(2*i);
    end
    checks++;
    if (RD !== exp) begin failures++; $display("[TB] FAIL masked_load: got %h expected %h", RD, exp); end
    for (int i = 0; i < 16; i++) wd[i*16 +: 16] = 16'hFFFF;
    wd[15:0] = 16'hBEEF;
    run_request(1'b1, 16'h0000, 8'd1, 16'h0001, wd, lat, ra, va);
    checks++;
    if (RD !== exp) begin failures++; $display("[TB] FAIL store_keeps_rd: got %h expected %h", RD, exp); end
    run_request(1'b0, 16'h0000, 8'd1, 16'hFFFF, 256'h0, lat, ra, va);
    exp[15:0] = 16'hBEEF;
    for (int i = 1; i < 8; i++) exp[i*16 +: 16] = 16'(i + 1);
    for (int i = 0; i < 4; i++) begin
      exp[(8+2*i)*16 +: 16] = 16'h0100 + 16'(i);
      exp[(9+2*i)*16 +: 16] = 16'h000A + 16'(2*i);
    end
    checks++;
    if (RD !== exp) begin failures++; $display("[TB] FAIL single_lane_store: got %h expected %h", RD, exp); end
  endtask

  task automatic test_wrap();
    logic [255:0] wd, exp;
    int lat;
    logic ra, va;
    for (int i = 0; i < 16; i++) wd[i*16 +: 16] = 16'hC000 + 16'(i);
    run_request(1'b1, 16'h01FE, 8'd1, 16'hFFFF, wd, lat, ra, va);
    run_request(1'b0, 16'h01FE, 8'd1, 16'hFFFF, 256'h0, lat, ra, va);
    checks++;
    if (RD !== wd) begin failures++; $display("[TB] FAIL wrap_readback: got %h expected %h", RD, wd); end
    run_request(1'b0, 16'h0000, 8'd1, 16'h0001, 256'h0, lat, ra, va);
    exp = '0;
    exp[15:0] = 16'hC001;
    checks++;
    if (RD !== exp) begin failures++; $display("[TB] FAIL wrap_low_addr: got %h expected %h", RD, exp); end
    run_request(1'b0, 16'h01FF, 8'd1, 16'h0003, 256'h0, lat, ra, va);
    exp = '0;
    exp[15:0]  = 16'h01C0;
    exp[31:16] = 16'h02C0;
    checks++;
    if (RD !== exp) begin failures++; $display("[TB] FAIL wrap_in_element: got %h expected %h", RD, exp); end
  endtask

  task automatic test_back_to_back();
    logic [255:0] wd, exp;
    int lat, pulses;
    logic ra, va;
    for (int i = 0; i < 16; i++) wd[i*16 +: 16] = 16'(i);
    @(negedge clk);
    REQ = 1'b1; WE = 1'b1; A = 16'h0100; STRIDE = 8'd0; MASK = 16'hFFFF; WD = wd;
    @(posedge clk); #1;
    A = 16'h0180; WD = {16{16'h5555}};
    pulses = 0;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); #1;
      if (VALID === 1'b1) begin
        pulses++;
        REQ = 1'b0;
      end
    end
    REQ = 1'b0;
    checks++;
    if (pulses !== 1) begin failures++; $display("[TB] FAIL req_held_pulses: got %0d expected 1", pulses); end
    checks++;
    if (READY !== 1'b1) begin failures++; $display("[TB] FAIL req_held_idle: got %b expected 1", READY); end
    run_request(1'b0, 16'h0100, 8'd1, 16'h0001, 256'h0, lat, ra, va);
    exp = '0;
    exp[15:0] = 16'h000F;
    checks++;
    if (RD !== exp) begin failures++; $display("[TB] FAIL stride0_last_wins: got %h expected %h", RD, exp); end
  endtask

  task automatic test_reset_mid_busy();
    logic [255:0] wd, exp;
    int lat;
    logic ra, va;
    for (int i = 0; i < 16; i++) wd[i*16 +: 16] = 16'h7700 + 16'(i);
    run_request(1'b1, 16'h0180, 8'd1, 16'hFFFF, wd, lat, ra, va);
    for (int i = 0; i < 16; i++) wd[i*16 +: 16] = 16'h3300 + 16'(i);
    @(negedge clk);
    REQ = 1'b1; WE = 1'b1; A = 16'h0180; STRIDE = 8'd1; MASK = 16'hFFFF; WD = wd;
    @(posedge clk); #1;
    REQ = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    RST = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (READY !== 1'b1) begin failures++; $display("[TB] FAIL abort_ready: got %b expected 1", READY); end
    checks++;
    if (VALID !== 1'b0) begin failures++; $display("[TB] FAIL abort_valid: got %b expected 0", VALID); end
    RST = 1'b0;
    run_request(1'b0, 16'h0180, 8'd1, 16'hFFFF, 256'h0, lat, ra, va);
    for (int i = 0; i < 16; i++) exp[i*16 +: 16] = (i < 8) ? 16'h3300 + 16'(i) : 16'h7700 + 16'(i);
    checks++;
    if (RD !== exp) begin failures++; $display("[TB] FAIL abort_partial_commit: got %h expected %h", RD, exp); end
  endtask

  initial begin
    test_reset();
    test_contiguous();
    test_stride();
    test_mask();
    test_wrap();
    test_back_to_back();
    test_reset_mid_busy();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
